// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//
// Decode-to-execute pipeline register. Captures the register-file operands,
// register indices, extended immediate, PC values and execute/memory/writeback
// control bits on every rising CLK, with stall (hold), flush (bubble insertion),
// a valid bit and a saturating count of flush-inserted bubbles.
//
// Priority at each rising CLK: RST > FLUSH_E > STALL_E > load.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   STALL_E, FLUSH_E         hold contents / replace contents with a bubble
//   VALID_D                  decode stage holds a real instruction
//   rd1_d .. pc_plus4_d      decode-stage data and index fields
//   *_D control bits         decode-stage control fields
//   rd1_e .. pc_plus4_e      registered data and index fields
//   *_E control bits         registered control fields
//   valid_e                  execute stage holds a real instruction
//   bubble_cnt               flush-inserted bubbles, saturating at all-ones
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STALL_E,
    input  logic              FLUSH_E,
    input  logic              VALID_D,
    input  logic [DATA_W-1:0] rd1_d,
    input  logic [DATA_W-1:0] rd2_d,
    input  logic [ADDR_W-1:0] rs1_d,
    input  logic [ADDR_W-1:0] rs2_d,
    input  logic [ADDR_W-1:0] rd_d,
    input  logic [DATA_W-1:0] imm_ext_d,
    input  logic [DATA_W-1:0] pc_d,
    input  logic [DATA_W-1:0] pc_plus4_d,
    input  logic              REG_WRITE_D,
    input  logic [1:0]        RESULT_SRC_D,
    input  logic              MEM_WRITE_D,
    input  logic              JUMP_D,
    input  logic              BRANCH_D,
    input  logic [2:0]        ALU_CONTROL_D,
    input  logic              ALU_SRC_D,
    output logic [DATA_W-1:0] rd1_e,
    output logic [DATA_W-1:0] rd2_e,
    output logic [ADDR_W-1:0] rs1_e,
    output logic [ADDR_W-1:0] rs2_e,
    output logic [ADDR_W-1:0] rd_e,
    output logic [DATA_W-1:0] imm_ext_e,
    output logic [DATA_W-1:0] pc_e,
    output logic [DATA_W-1:0] pc_plus4_e,
    output logic              REG_WRITE_E,
    output logic [1:0]        RESULT_SRC_E,
    output logic              MEM_WRITE_E,
    output logic              JUMP_E,
    output logic              BRANCH_E,
    output logic [2:0]        ALU_CONTROL_E,
    output logic              ALU_SRC_E,
    output logic              valid_e,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // NOTE: every register here is written with <= so all fields update
    // together from the values sampled at the edge; blocking = would let
    // later statements in the block see already-updated state.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH_E) begin
            // Reset and flush both leave an all-zero bubble; rd_e = 0 means
            // no forwarding or hazard logic can match on it.
            rd1_e         <= '0;
            rd2_e         <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
            imm_ext_e     <= '0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
            REG_WRITE_E   <= 1'b0;
            RESULT_SRC_E  <= 2'b00;
            MEM_WRITE_E   <= 1'b0;
            JUMP_E        <= 1'b0;
            BRANCH_E      <= 1'b0;
            ALU_CONTROL_E <= 3'b000;
            ALU_SRC_E     <= 1'b0;
            valid_e       <= 1'b0;
        end else if (!STALL_E) begin
            rd1_e         <= rd1_d;
            rd2_e         <= rd2_d;
            rs1_e         <= rs1_d;
            rs2_e         <= rs2_d;
            rd_e          <= rd_d;
            imm_ext_e     <= imm_ext_d;
            pc_e          <= pc_d;
            pc_plus4_e    <= pc_plus4_d;
            // An invalid slot must never carry side-effecting controls, so
            // all controls are gated by VALID_D while the data still loads.
            REG_WRITE_E   <= VALID_D & REG_WRITE_D;
            RESULT_SRC_E  <= VALID_D ? RESULT_SRC_D : 2'b00;
            MEM_WRITE_E   <= VALID_D & MEM_WRITE_D;
            JUMP_E        <= VALID_D & JUMP_D;
            BRANCH_E      <= VALID_D & BRANCH_D;
            ALU_CONTROL_E <= VALID_D ? ALU_CONTROL_D : 3'b000;
            ALU_SRC_E     <= VALID_D & ALU_SRC_D;
            valid_e       <= VALID_D;
        end
    end

    // Counts flushes (including flush+stall); saturates instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bubble_cnt <= '0;
        end else if (FLUSH_E && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    logic        CLK = 1'b0;
    logic        RST, STALL_E, FLUSH_E, VALID_D;
    logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        REG_WRITE_D, MEM_WRITE_D, JUMP_D, BRANCH_D, ALU_SRC_D;
    logic [1:0]  RESULT_SRC_D;
    logic [2:0]  ALU_CONTROL_D;

    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        REG_WRITE_E, MEM_WRITE_E, JUMP_E, BRANCH_E, ALU_SRC_E, valid_e;
    logic [1:0]  RESULT_SRC_E;
    logic [2:0]  ALU_CONTROL_E;
    logic [31:0] bubble_cnt;

    // Narrow-counter instance for the saturation check; shares all inputs.
    logic [31:0] s_rd1_e, s_rd2_e, s_imm_ext_e, s_pc_e, s_pc_plus4_e;
    logic [4:0]  s_rs1_e, s_rs2_e, s_rd_e;
    logic        s_reg_write_e, s_mem_write_e, s_jump_e, s_branch_e, s_alu_src_e, s_valid_e;
    logic [1:0]  s_result_src_e;
    logic [2:0]  s_alu_control_e;
    logic [3:0]  s_bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    id_ex_pipe_reg dut (
        .CLK(CLK), .RST(RST), .STALL_E(STALL_E), .FLUSH_E(FLUSH_E), .VALID_D(VALID_D),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .REG_WRITE_D(REG_WRITE_D), .RESULT_SRC_D(RESULT_SRC_D), .MEM_WRITE_D(MEM_WRITE_D),
        .JUMP_D(JUMP_D), .BRANCH_D(BRANCH_D), .ALU_CONTROL_D(ALU_CONTROL_D), .ALU_SRC_D(ALU_SRC_D),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .REG_WRITE_E(REG_WRITE_E), .RESULT_SRC_E(RESULT_SRC_E), .MEM_WRITE_E(MEM_WRITE_E),
        .JUMP_E(JUMP_E), .BRANCH_E(BRANCH_E), .ALU_CONTROL_E(ALU_CONTROL_E), .ALU_SRC_E(ALU_SRC_E),
        .valid_e(valid_e), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_reg #(.CNT_W(4)) dut_sat (
        .CLK(CLK), .RST(RST), .STALL_E(STALL_E), .FLUSH_E(FLUSH_E), .VALID_D(VALID_D),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .REG_WRITE_D(REG_WRITE_D), .RESULT_SRC_D(RESULT_SRC_D), .MEM_WRITE_D(MEM_WRITE_D),
        .JUMP_D(JUMP_D), .BRANCH_D(BRANCH_D), .ALU_CONTROL_D(ALU_CONTROL_D), .ALU_SRC_D(ALU_SRC_D),
        .rd1_e(s_rd1_e), .rd2_e(s_rd2_e), .rs1_e(s_rs1_e), .rs2_e(s_rs2_e), .rd_e(s_rd_e),
        .imm_ext_e(s_imm_ext_e), .pc_e(s_pc_e), .pc_plus4_e(s_pc_plus4_e),
        .REG_WRITE_E(s_reg_write_e), .RESULT_SRC_E(s_result_src_e), .MEM_WRITE_E(s_mem_write_e),
        .JUMP_E(s_jump_e), .BRANCH_E(s_branch_e), .ALU_CONTROL_E(s_alu_control_e), .ALU_SRC_E(s_alu_src_e),
        .valid_e(s_valid_e), .bubble_cnt(s_bubble_cnt)
    );

    typedef struct {
        logic        rst, flush, stall, valid;
        logic [31:0] rd1, rd2, pc;
        logic [4:0]  rd;
        logic        regw, memw, branch;
        logic [31:0] e_rd1, e_rd2, e_pc;
        logic [4:0]  e_rd;
        logic        e_regw, e_memw, e_branch, e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Side-effecting controls must be zero whenever the slot is invalid.
    task automatic check_invariant(input string tag);
        if (!valid_e)
            check({tag, " invalid-slot controls"}, {60'd0, REG_WRITE_E, MEM_WRITE_E, JUMP_E, BRANCH_E}, 64'd0);
    endtask

    task automatic clear_inputs();
        RST = 0; STALL_E = 0; FLUSH_E = 0; VALID_D = 0;
        rd1_d = 0; rd2_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
        imm_ext_d = 0; pc_d = 0; pc_plus4_d = 0;
        REG_WRITE_D = 0; RESULT_SRC_D = 0; MEM_WRITE_D = 0;
        JUMP_D = 0; BRANCH_D = 0; ALU_CONTROL_D = 0; ALU_SRC_D = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " data"}, {rd1_e, rd2_e}, 64'd0);
        check({tag, " imm/pc"}, {imm_ext_e | pc_e | pc_plus4_e, 17'd0, rs1_e, rs2_e, rd_e}, 64'd0);
        check({tag, " controls"}, {52'd0, REG_WRITE_E, RESULT_SRC_E, MEM_WRITE_E, JUMP_E, BRANCH_E,
                                   ALU_CONTROL_E, ALU_SRC_E, valid_e}, 64'd0);
    endtask

    initial begin
        clear_inputs();
        RST = 1;
        tick();
        tick();
        check_all_zero("reset");
        check("reset bubble_cnt", bubble_cnt, 0);
        check("reset sat bubble_cnt", s_bubble_cnt, 0);
        RST = 0;

        //            rst flush stall valid rd1           rd2           pc      rd  rw mw br | e_rd1        e_rd2        e_pc    e_rd rw mw br v  cnt
        vecs[0]  = '{0, 0, 0, 1, 32'hDEADBEEF, 32'h12345678, 32'h0,   5, 1, 0, 0, 32'hDEADBEEF, 32'h12345678, 32'h0,   5, 1, 0, 0, 1, 0};
        vecs[1]  = '{0, 0, 1, 1, 32'h1,        32'h2,        32'h100, 9, 0, 0, 0, 32'hDEADBEEF, 32'h12345678, 32'h0,   5, 1, 0, 0, 1, 0};
        vecs[2]  = '{0, 0, 1, 1, 32'h1,        32'h2,        32'h100, 9, 0, 0, 0, 32'hDEADBEEF, 32'h12345678, 32'h0,   5, 1, 0, 0, 1, 0};
        vecs[3]  = '{0, 0, 1, 1, 32'h1,        32'h2,        32'h100, 9, 0, 0, 0, 32'hDEADBEEF, 32'h12345678, 32'h0,   5, 1, 0, 0, 1, 0};
        vecs[4]  = '{0, 0, 0, 1, 32'h1,        32'h2,        32'h100, 9, 0, 0, 0, 32'h1,        32'h2,        32'h100, 9, 0, 0, 0, 1, 0};
        vecs[5]  = '{0, 1, 0, 1, 32'h55,       32'h66,       32'h104, 7, 1, 1, 0, 32'h0,        32'h0,        32'h0,   0, 0, 0, 0, 0, 1};
        vecs[6]  = '{0, 0, 0, 1, 32'h3,        32'h4,        32'h200, 10, 1, 1, 0, 32'h3,       32'h4,        32'h200, 10, 1, 1, 0, 1, 1};
        vecs[7]  = '{0, 1, 1, 1, 32'h77,       32'h88,       32'h204, 11, 1, 1, 1, 32'h0,       32'h0,        32'h0,   0, 0, 0, 0, 0, 2};
        vecs[8]  = '{0, 0, 0, 0, 32'hAA,       32'hBB,       32'h300, 12, 1, 1, 1, 32'hAA,      32'hBB,       32'h300, 12, 0, 0, 0, 0, 2};
        vecs[9]  = '{0, 0, 0, 1, 32'h5,        32'h6,        32'h304, 0, 0, 0, 1, 32'h5,        32'h6,        32'h304, 0, 0, 0, 1, 1, 2};
        vecs[10] = '{0, 0, 1, 0, 32'h9,        32'h9,        32'h308, 3, 1, 1, 0, 32'h5,        32'h6,        32'h304, 0, 0, 0, 1, 1, 2};
        vecs[11] = '{1, 1, 1, 1, 32'h9,        32'h9,        32'h30C, 3, 1, 1, 1, 32'h0,        32'h0,        32'h0,   0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            RST = vecs[i].rst; FLUSH_E = vecs[i].flush; STALL_E = vecs[i].stall;
            VALID_D = vecs[i].valid; rd1_d = vecs[i].rd1; rd2_d = vecs[i].rd2;
            pc_d = vecs[i].pc; rd_d = vecs[i].rd; REG_WRITE_D = vecs[i].regw;
            MEM_WRITE_D = vecs[i].memw; BRANCH_D = vecs[i].branch;
            tick();
            check($sformatf("v%0d rd1_e", i), rd1_e, vecs[i].e_rd1);
            check($sformatf("v%0d rd2_e", i), rd2_e, vecs[i].e_rd2);
            check($sformatf("v%0d pc_e", i), pc_e, vecs[i].e_pc);
            check($sformatf("v%0d rd_e", i), rd_e, vecs[i].e_rd);
            check($sformatf("v%0d ctl{rw,mw,br}", i), {REG_WRITE_E, MEM_WRITE_E, BRANCH_E},
                  {vecs[i].e_regw, vecs[i].e_memw, vecs[i].e_branch});
            check($sformatf("v%0d valid_e", i), valid_e, vecs[i].e_valid);
            check($sformatf("v%0d bubble_cnt", i), bubble_cnt, vecs[i].e_cnt);
            check($sformatf("v%0d sat bubble_cnt", i), s_bubble_cnt, vecs[i].e_cnt[3:0]);
            check_invariant($sformatf("v%0d", i));
        end

        // Every field carried through a valid load.
        clear_inputs();
        VALID_D = 1; rd1_d = 32'hCAFEF00D; rd2_d = 32'h0BADC0DE; rs1_d = 5'd3; rs2_d = 5'd4;
        rd_d = 5'd31; imm_ext_d = 32'hFFFFF800; pc_d = 32'h1000; pc_plus4_d = 32'h1004;
        REG_WRITE_D = 1; RESULT_SRC_D = 2'b10; MEM_WRITE_D = 1; JUMP_D = 1; BRANCH_D = 1;
        ALU_CONTROL_D = 3'b101; ALU_SRC_D = 1;
        tick();
        check("full data", {rd1_e, rd2_e}, 64'hCAFEF00D_0BADC0DE);
        check("full idx", {rs1_e, rs2_e, rd_e}, {5'd3, 5'd4, 5'd31});
        check("full imm/pc", {imm_ext_e, pc_e}, 64'hFFFFF800_00001000);
        check("full pc_plus4", pc_plus4_e, 32'h1004);
        check("full controls", {REG_WRITE_E, RESULT_SRC_E, MEM_WRITE_E, JUMP_E, BRANCH_E, ALU_CONTROL_E, ALU_SRC_E, valid_e},
              {1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 3'b101, 1'b1, 1'b1});

        // Same fields with VALID_D low: data loads, all controls gated off.
        VALID_D = 0; rd1_d = 32'h11111111; imm_ext_d = 32'h22; pc_plus4_d = 32'h2004;
        tick();
        check("inv data", {rd1_e, imm_ext_e}, 64'h11111111_00000022);
        check("inv pc_plus4", pc_plus4_e, 32'h2004);
        check("inv controls", {REG_WRITE_E, RESULT_SRC_E, MEM_WRITE_E, JUMP_E, BRANCH_E, ALU_CONTROL_E, ALU_SRC_E, valid_e}, 11'd0);
        check_invariant("inv");

        // Flush clears every field, including rs/imm/pc+4.
        VALID_D = 1; FLUSH_E = 1;
        tick();
        check_all_zero("flush");
        check("flush bubble_cnt", bubble_cnt, 1);

        // Saturation: 15 flushes reach 0xF on the 4-bit counter, the 16th holds it.
        clear_inputs();
        RST = 1;
        tick();
        RST = 0; FLUSH_E = 1;
        repeat (15) tick();
        check("sat after 15", s_bubble_cnt, 4'hF);
        check("wide after 15", bubble_cnt, 15);
        tick();
        check("sat after 16", s_bubble_cnt, 4'hF);
        check("wide after 16", bubble_cnt, 16);
        RST = 1;
        tick();
        check("rst+flush sat cnt", s_bubble_cnt, 0);
        check("rst+flush wide cnt", bubble_cnt, 0);
        check_all_zero("rst+flush");
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
